// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and data-memory handshake states.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_dmem_handshake_fsm.sv
// Data-memory req/ack sequencer: raises the request as soon as a memory
// access reaches MEM, stalls the pipe until ack, flags a sticky timeout.
module dmem_handshake_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_acc,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic dmem_err
);

  localparam int unsigned WC_W = $clog2(MAX_WAIT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WAIT - 1);

  dmem_state_e     state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            err_nxt;
  logic            req_c, stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dmem_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      dmem_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = dmem_err;
    req_c        = 1'b0;
    stall_c      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_acc && !dmem_err) begin
          req_c        = 1'b1;
          stall_c      = 1'b1;
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = mem_acc;
        if (dmem_ack) begin
          state_nxt = ST_DONE;
        end else if (wait_cnt == WC_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated by rst_n so the request drops in the same cycle reset is asserted.
  assign dmem_req  = rst_n & req_c;
  assign mem_stall = rst_n & stall_c;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage core: pipeline register
// hold/bubble controls, EX operand forwarding and the dmem wait stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_we,
  input  logic             ex_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_we,
  input  logic             mem_acc,
  input  logic             mem_br_taken,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_we,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             hold_ifid,
  output logic             hold_idex,
  output logic             hold_exmem,
  output logic             bub_idex,
  output logic             bub_exmem,
  output logic             bub_memwb,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic     mem_stall, br_flush, load_use;
  fwd_sel_e fa, fb;

  dmem_handshake_fsm #(.MAX_WAIT(MAX_WAIT)) u_dmem (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_acc   (mem_acc),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .mem_stall (mem_stall),
    .dmem_err  (dmem_err)
  );

  // A load sitting in MEM has no data yet; the load-use bubble covers it.
  function automatic fwd_sel_e pick_fwd(input logic [RA_W-1:0] src,
                                        input logic [RA_W-1:0] m_rd,
                                        input logic m_we, input logic m_ld,
                                        input logic [RA_W-1:0] w_rd,
                                        input logic w_we);
    if (src == '0)                         return FWD_RF;
    if (m_we && !m_ld && (m_rd == src))    return FWD_MEM;
    if (w_we && (w_rd == src))             return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    load_use = ex_load & ex_we & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    br_flush = rst_n & mem_br_taken & !mem_stall;
    load_use = rst_n & load_use & !mem_stall & !mem_br_taken;

    hold_ifid  = mem_stall | load_use;
    hold_idex  = mem_stall;
    hold_exmem = mem_stall;
    bub_memwb  = mem_stall;
    bub_idex   = br_flush | load_use;
    bub_exmem  = br_flush;
    flush_ifid = br_flush;

    fa = pick_fwd(id_rs1, mem_rd, mem_we, mem_acc, wb_rd, wb_we);
    fb = pick_fwd(id_rs2, mem_rd, mem_we, mem_acc, wb_rd, wb_we);
    fwd_a = rst_n ? fa : FWD_RF;
    fwd_b = rst_n ? fb : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hold_ifid || hold_idex || hold_exmem) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: fixed vectors, dmem handshake
// sequences and randomized cycles against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MAXW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_we, ex_load, mem_we, mem_acc;
  logic        mem_br_taken, wb_we, dmem_ack;
  logic        dmem_req, hold_ifid, hold_idex, hold_exmem;
  logic        bub_idex, bub_exmem, bub_memwb, flush_ifid, dmem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(5), .MAX_WAIT(MAXW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_acc(mem_acc), .mem_br_taken(mem_br_taken),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .hold_ifid(hold_ifid), .hold_idex(hold_idex), .hold_exmem(hold_exmem),
    .bub_idex(bub_idex), .bub_exmem(bub_exmem), .bub_memwb(bub_memwb),
    .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_err(dmem_err), .stall_cnt(stall_cnt)
  );

  // {req, hold_ifid, hold_idex, hold_exmem, bub_idex, bub_exmem, bub_memwb, flush_ifid, fwd_a, fwd_b}
  logic [11:0] dut_o;
  assign dut_o = {dmem_req, hold_ifid, hold_idex, hold_exmem, bub_idex, bub_exmem,
                  bub_memwb, flush_ifid, fwd_a, fwd_b};

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] ex_rd;
    logic       ex_we, ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we, mem_acc, br;
    logic [4:0] wb_rd;
    logic       wb_we, ack;
  } in_t;

  typedef struct {
    in_t         i;
    logic [11:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: transaction in progress, cycles waited so far,
  // one release cycle after ack, sticky timeout, stall-cycle tally.
  bit          m_wait, m_done, m_err;
  int          m_waited;
  logic [31:0] m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic in_t vi(input int rs1, input int rs2, input int u1, input int u2,
                             input int exrd, input int exwe, input int exld,
                             input int memrd, input int memwe, input int br,
                             input int wbrd, input int wbwe);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1[0]; v.u2 = u2[0];
    v.ex_rd = 5'(exrd); v.ex_we = exwe[0]; v.ex_ld = exld[0];
    v.mem_rd = 5'(memrd); v.mem_we = memwe[0]; v.mem_acc = 1'b0; v.br = br[0];
    v.wb_rd = 5'(wbrd); v.wb_we = wbwe[0]; v.ack = 1'b0;
    return v;
  endfunction

  function automatic logic [1:0] m_fwd(input in_t v, input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (v.mem_we && !v.mem_acc && v.mem_rd == src) return 2'b01;
    if (v.wb_we && v.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model(input in_t v);
    bit st, lu, br, req;
    st  = v.mem_acc && !m_err && !m_done;
    req = m_wait || st;
    br  = v.br && !st;
    lu  = v.ex_ld && v.ex_we && v.ex_rd != 0 &&
          ((v.u1 && v.rs1 == v.ex_rd) || (v.u2 && v.rs2 == v.ex_rd)) && !st && !br;
    return {req, st | lu, st, st, br | lu, br, st, br, m_fwd(v, v.rs1), m_fwd(v, v.rs2)};
  endfunction

  task automatic model_step(input in_t v, input logic [11:0] e);
    if (e[10] || e[9] || e[8]) m_cnt = m_cnt + 1;
    if (m_done) begin
      m_done = 0;
    end else if (m_wait) begin
      if (v.ack) begin
        m_wait = 0; m_done = 1;
      end else if (m_waited == MAXW - 1) begin
        m_wait = 0; m_err = 1;
      end else begin
        m_waited++;
      end
    end else if (v.mem_acc && !m_err) begin
      m_wait = 1; m_waited = 0;
    end
  endtask

  task automatic drive(input in_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.ex_rd; ex_we = v.ex_we; ex_load = v.ex_ld;
    mem_rd = v.mem_rd; mem_we = v.mem_we; mem_acc = v.mem_acc; mem_br_taken = v.br;
    wb_rd = v.wb_rd; wb_we = v.wb_we; dmem_ack = v.ack;
  endtask

  // One clock cycle: drive after the edge, compare on the falling edge.
  task automatic apply(input in_t v, input logic [11:0] exp_tab, input bit from_tab,
                       input string nm);
    logic [11:0] e, em;
    @(posedge clk); #1;
    drive(v);
    em = model(v);
    e  = from_tab ? exp_tab : em;
    @(negedge clk);
    check({nm, ".out"}, 32'(dut_o), 32'(e));
    check({nm, ".stall_cnt"}, stall_cnt, m_cnt);
    check({nm, ".dmem_err"}, 32'(dmem_err), 32'(m_err));
    model_step(v, em);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_wait = 0; m_done = 0; m_err = 0; m_waited = 0; m_cnt = '0;
    repeat (2) @(negedge clk);
    drive(vi(0,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;
  endtask

  vec_t tab[13];

  initial begin
    in_t v;
    int  reqc, n;
    logic [31:0] cnt0;

    tab[0]  = '{vi(5,1,1,1, 5,1,1, 0,0,0, 0,0), 12'b0100_1000_0000};
    tab[1]  = '{vi(0,1,1,1, 0,1,1, 0,0,0, 0,0), 12'b0000_0000_0000};
    tab[2]  = '{vi(2,9,1,1, 9,1,1, 0,0,0, 0,0), 12'b0100_1000_0000};
    tab[3]  = '{vi(5,1,0,1, 5,1,1, 0,0,0, 0,0), 12'b0000_0000_0000};
    tab[4]  = '{vi(5,1,1,1, 5,1,0, 0,0,0, 0,0), 12'b0000_0000_0000};
    tab[5]  = '{vi(5,1,1,1, 5,0,1, 0,0,0, 0,0), 12'b0000_0000_0000};
    tab[6]  = '{vi(7,2,1,1, 0,0,0, 7,1,0, 7,1), 12'b0000_0000_0100};
    tab[7]  = '{vi(7,7,1,1, 0,0,0, 7,0,0, 7,1), 12'b0000_0000_1010};
    tab[8]  = '{vi(0,0,1,1, 0,0,0, 0,1,0, 0,1), 12'b0000_0000_0000};
    tab[9]  = '{vi(4,6,1,1, 0,0,0, 6,1,0, 4,1), 12'b0000_0000_1001};
    tab[10] = '{vi(1,2,1,1, 0,0,0, 0,0,1, 0,0), 12'b0000_1101_0000};
    tab[11] = '{vi(5,1,1,1, 5,1,1, 0,0,1, 0,0), 12'b0000_1101_0000};
    tab[12] = '{vi(1,2,1,1, 0,0,0, 0,0,0, 0,0), 12'b0000_0000_0000};

    // Reset with a memory access and a load-use pattern present: all outputs low.
    rst_n = 1'b0;
    v = vi(5,1,1,1, 5,1,1, 5,1,1, 5,1);
    v.mem_acc = 1'b1;
    drive(v);
    m_wait = 0; m_done = 0; m_err = 0; m_waited = 0; m_cnt = '0;
    #12;
    check("reset.out", 32'(dut_o), 32'h0);
    check("reset.stall_cnt", stall_cnt, 32'h0);
    check("reset.dmem_err", 32'(dmem_err), 32'h0);
    @(negedge clk);
    drive(vi(0,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) apply(tab[k].i, tab[k].exp, 1'b1, $sformatf("vec%0d", k));

    // Access in MEM with a taken branch alongside; ack on the 4th request cycle.
    cnt0 = m_cnt;
    reqc = 0;
    for (int k = 0; k < 4; k++) begin
      v = vi(3,0,1,1, 0,0,0, 3,1,1, 3,1);
      v.mem_acc = 1'b1;
      v.ack = (k == 3);
      apply(v, '0, 1'b0, $sformatf("acc%0d", k));
      if (dut_o[11]) reqc++;
    end
    check("acc.req_cycles", 32'(reqc), 32'd4);
    v = vi(0,0,0,0, 0,0,0, 0,0,1, 0,0);
    v.mem_acc = 1'b1;
    apply(v, 12'b0000_1101_0000, 1'b1, "acc.release");
    check("acc.stall_delta", stall_cnt - cnt0, 32'd4);
    apply(vi(0,0,0,0,0,0,0,0,0,0,0,0), 12'b0, 1'b1, "acc.idle");

    // No ack at all: request for the IDLE cycle plus MAXW wait cycles, then sticky error.
    reqc = 0;
    n = 0;
    v = vi(0,0,0,0,0,0,0,0,0,0,0,0);
    v.mem_acc = 1'b1;
    while (n < 40 && dmem_err !== 1'b1) begin
      apply(v, '0, 1'b0, "timeout");
      if (dut_o[11]) reqc++;
      n++;
    end
    check("timeout.req_cycles", 32'(reqc), 32'(MAXW + 1));
    check("timeout.err_set", 32'(dmem_err), 32'd1);
    apply(v, 12'b0, 1'b1, "err.bypass");
    apply(v, '0, 1'b0, "err.bypass2");

    // Reset asserted mid-wait: request drops without waiting for a clock edge.
    do_reset();
    for (int k = 0; k < 3; k++) apply(v, '0, 1'b0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.req", 32'(dmem_req), 32'h0);
    check("rst_mid.err", 32'(dmem_err), 32'h0);
    check("rst_mid.hold", 32'(hold_ifid), 32'h0);
    do_reset();
    apply(vi(0,0,0,0,0,0,0,0,0,0,0,0), 12'b0, 1'b1, "post_rst");

    for (int k = 0; k < 400; k++) begin
      v = vi($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,3), $urandom_range(0,1), ($urandom_range(0,7) == 0),
             $urandom_range(0,3), $urandom_range(0,1));
      v.mem_acc = ($urandom_range(0,3) == 0);
      v.ack = ($urandom_range(0,2) == 0);
      apply(v, '0, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
